neorv32_wb_bridge: RTL and testbench
====================================

# neorv32_wb_bridge

Bus adapter between the NEORV32 CPU core and the processor_ci Wishbone-classic master port. It captures the CPU's single-cycle instruction-bus (ibus) and data-bus (dbus) request strobes and arbitrates them round-robin onto one Wishbone port (`core_cyc`/`core_stb`/`core_we`/`core_addr`/`core_data_*`/`core_ack`). Because that port has no byte-select, the bridge performs read-modify-write for partial stores. It also returns single-cycle ack/err pulses to the CPU and enforces a bus timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles without `core_ack_i` before an access is aborted with err; range 1..65535.
- `RMW_EN`, 1: 1 = partial stores use read-modify-write; 0 = partial stores respond err with no Wishbone cycle.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ibus_stb_i`  in  1  fetch request strobe, one-cycle pulse.
- `ibus_addr_i`  in  32  fetch address.
- `ibus_rdata_o`  out  32  fetched word.
- `ibus_ack_o`  out  1  fetch done pulse.
- `ibus_err_o`  out  1  fetch error pulse.
- `dbus_stb_i`  in  1  data request strobe, one-cycle pulse.
- `dbus_rw_i`  in  1  1 = write.
- `dbus_addr_i`  in  32  data address.
- `dbus_wdata_i`  in  32  store data, lane-aligned.
- `dbus_ben_i`  in  4  byte enables.
- `dbus_amo_i`  in  1  atomic request flag.
- `dbus_rdata_o`  out  32  load word.
- `dbus_ack_o`  out  1  data done pulse.
- `dbus_err_o`  out  1  data error pulse.
- `core_cyc_o`, `core_stb_o`, `core_we_o`  out  1 each  Wishbone control.
- `core_addr_o`  out  32  word-aligned address.
- `core_data_o`  out  32  write data.
- `core_data_i`  in  32  read data.
- `core_ack_i`  in  1  Wishbone acknowledge.

## Operation
- **Request capture.** Each bus has a slot that latches addr/wdata/ben/rw/amo and sets `pending` on its stb.
  - A stb that arrives while that bus is already pending is ignored.
  - `pending` clears in the cycle the response pulse is driven.
- **Arbitration** happens in IDLE only.
  - One slot pending: grant it.
  - Both pending: grant the slot not granted last. `last_grant` resets to ibus, so dbus wins the first tie.
- **FSM states:** IDLE, RD, WR, RMW_RD, RMW_MERGE, RMW_WR, RESP.
  - IDLE → RESP (err) if dbus has `amo=1`, or if `RMW_EN=0` and the access is a write with `ben≠4'hF`.
  - IDLE → WR for a write with `ben=4'hF`.
  - IDLE → RMW_RD for a write with `ben≠4'hF` and `RMW_EN=1`.
  - IDLE → RD for every read; `ben` is ignored and the full word is returned, lane extraction is done by the CPU.
  - RD / WR / RMW_WR: `core_ack_i` → RESP (ack); timeout → RESP (err).
  - RMW_RD: ack → RMW_MERGE, capturing `core_data_i`; timeout → RESP (err).
  - RMW_MERGE: byte lane i = `ben[i] ? wdata : readback`, then → RMW_WR.
  - RESP → IDLE.
- **Wishbone address** is always `{addr[31:2],2'b00}`.
- **Bus control:**
  - `core_stb_o` and `core_cyc_o` are high in RD, WR, RMW_RD and RMW_WR.
  - `core_cyc_o` also stays high in RMW_MERGE; only `stb` drops there, which keeps the RMW atomic on the bus.
  - `core_we_o` is high in WR and RMW_WR.
- **Timeout counter** (16 bit) clears on entry to each bus-phase state and increments each cycle without ack. Err is raised when count = `TIMEOUT_CYCLES`−1 with no ack. An ack in that same cycle wins over the timeout.
- **Response:** RESP drives exactly one of ack/err for one cycle, on the granted bus only, and drives rdata (readback for reads, 0 otherwise).

## Timing
- Reset values: all outputs 0, state IDLE, both slots empty.
- Reset asserted mid-access drops `cyc`/`stb` immediately (asynchronously) and loses the request without a response.
- All outputs are registered.
- Read/full write: stb at cycle N → `cyc`/`stb` high at N+2. Ack sampled at cycle M → `cyc` low and ack/err pulse both at M+1.
- Zero-wait slave (ack in the first bus cycle): response at N+4.
- RMW: read phase, one MERGE cycle with `stb` low, then write phase. With zero-wait ack the response arrives at N+7.
- Error with no bus cycle (amo, or partial write with `RMW_EN=0`): err pulse at N+3.
- Back-to-back: after RESP the bridge returns to IDLE, so the next grant's `stb` goes high two cycles after the previous response.
- A stb that arrives in the same cycle as that bus's response pulse is captured; its slot clears and re-sets in the same cycle.

## Structure
- Package `neorv32_wb_pkg`:
  - `bridge_state_t` enum.
  - `grant_t` {GNT_IBUS, GNT_DBUS}.
  - `TIMEOUT_W = 16`.
  - `WORD_ALIGN_MASK`.
- Sub-module `neorv32_wb_req_slot`, instantiated once per bus: capture registers, `pending` flag, `clear` input.
- Top module holds the arbiter, FSM, merge logic and timeout counter.

## Test plan
- **Basic fetch:** ibus stb, addr 0x104, slave acks 1 cycle later with 0xDEADBEEF → `core_addr_o`=0x104, `we`=0; `ibus_ack_o` one pulse with rdata 0xDEADBEEF; no dbus activity.
- **Tie:** ibus and dbus stb in the same cycle → dbus served first, ibus served immediately after; the next tie is won by ibus.
- **Partial store:** memory word 0x11223344, store `ben`=4'b0010 with wdata 0x0000AA00 → read then write 0x1122AA44; `cyc` high continuously across both phases; one `dbus_ack_o`.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never acks → `cyc` drops after 8 bus cycles; one `dbus_err_o`, no ack.
- **Unsupported requests:** `amo`=1, or a partial store with `RMW_EN`=0 → err pulse at N+3 with `cyc` never asserted.
- **Reset mid-RMW:** `rst_n` low during RMW_WR → all outputs 0 immediately; after release a new fetch completes normally.

Source files
------------

// File: rtl/neorv32_wb_pkg.sv
// Shared types for the NEORV32 to Wishbone-classic bridge.
// State encoding, grant ids and the store-lane merge helper.
package neorv32_wb_pkg;

  localparam int TIMEOUT_W = 16;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_MERGE,
    S_RMW_WR,
    S_RESP
  } bridge_state_t;

  typedef enum logic {
    GNT_IBUS,
    GNT_DBUS
  } grant_t;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] rd,
    input logic [31:0] wd,
    input logic [3:0]  ben
  );
    logic [31:0] m;
    m = rd;
    for (int i = 0; i < 4; i++) begin
      if (ben[i]) m[8*i +: 8] = wd[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/neorv32_wb_req_slot.sv
// One captured CPU request; holds fields stable while pending.
// A strobe in the clear cycle re-arms the slot immediately.
module neorv32_wb_req_slot
  import neorv32_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  ben,
  input  logic        amo,
  input  logic        clear,
  output logic        pending,
  output logic        rw_q,
  output logic [31:0] addr_q,
  output logic [31:0] wdata_q,
  output logic [3:0]  ben_q,
  output logic        amo_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      amo_q   <= 1'b0;
    end else if (stb && (!pending || clear)) begin
      pending <= 1'b1;
      rw_q    <= rw;
      addr_q  <= addr;
      wdata_q <= wdata;
      ben_q   <= ben;
      amo_q   <= amo;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/neorv32_wb_bridge.sv
// NEORV32 ibus/dbus to single Wishbone-classic master port.
// Round-robin arbiter, RMW for partial stores, bus timeout.
module neorv32_wb_bridge
  import neorv32_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RMW_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_stb_i,
  input  logic [31:0] ibus_addr_i,
  output logic [31:0] ibus_rdata_o,
  output logic        ibus_ack_o,
  output logic        ibus_err_o,
  input  logic        dbus_stb_i,
  input  logic        dbus_rw_i,
  input  logic [31:0] dbus_addr_i,
  input  logic [31:0] dbus_wdata_i,
  input  logic [3:0]  dbus_ben_i,
  input  logic        dbus_amo_i,
  output logic [31:0] dbus_rdata_o,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic        core_cyc_o,
  output logic        core_stb_o,
  output logic        core_we_o,
  output logic [31:0] core_addr_o,
  output logic [31:0] core_data_o,
  input  logic [31:0] core_data_i,
  input  logic        core_ack_i
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t        state;
  grant_t               gnt_q, last_gnt, sel;
  logic                 hold;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [31:0]          rdbuf;

  logic        i_pend, i_rw, i_amo;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_ben;
  logic        d_pend, d_rw, d_amo;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_ben;

  logic        s_rw, s_amo, s_full, s_bad;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_ben;
  logic        bus_ph, tmo_hit, fin_ok, fin_err, use_d;
  logic [31:0] rd_word;

  neorv32_wb_req_slot u_islot (
    .clk     (clk),
    .rst_n   (rst_n),
    .stb     (ibus_stb_i),
    .rw      (1'b0),
    .addr    (ibus_addr_i),
    .wdata   (32'h0),
    .ben     (4'hF),
    .amo     (1'b0),
    .clear   (ibus_ack_o | ibus_err_o),
    .pending (i_pend),
    .rw_q    (i_rw),
    .addr_q  (i_addr),
    .wdata_q (i_wdata),
    .ben_q   (i_ben),
    .amo_q   (i_amo)
  );

  neorv32_wb_req_slot u_dslot (
    .clk     (clk),
    .rst_n   (rst_n),
    .stb     (dbus_stb_i),
    .rw      (dbus_rw_i),
    .addr    (dbus_addr_i),
    .wdata   (dbus_wdata_i),
    .ben     (dbus_ben_i),
    .amo     (dbus_amo_i),
    .clear   (dbus_ack_o | dbus_err_o),
    .pending (d_pend),
    .rw_q    (d_rw),
    .addr_q  (d_addr),
    .wdata_q (d_wdata),
    .ben_q   (d_ben),
    .amo_q   (d_amo)
  );

  always_comb begin
    sel = gnt_q;
    if (state == S_IDLE) begin
      if (i_pend && d_pend)
        sel = (last_gnt == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
      else if (d_pend)
        sel = GNT_DBUS;
      else
        sel = GNT_IBUS;
    end
  end

  always_comb begin
    use_d   = (sel == GNT_DBUS);
    s_rw    = use_d ? d_rw    : i_rw;
    s_amo   = use_d ? d_amo   : i_amo;
    s_addr  = use_d ? d_addr  : i_addr;
    s_wdata = use_d ? d_wdata : i_wdata;
    s_ben   = use_d ? d_ben   : i_ben;
    s_full  = (s_ben == 4'hF);
    s_bad   = s_amo || (s_rw && !s_full && !RMW_EN);
    bus_ph  = state inside {S_RD, S_WR, S_RMW_RD, S_RMW_WR};
    tmo_hit = bus_ph && !core_ack_i && (tmo_cnt == TMO_LAST);
    fin_ok  = core_ack_i && (state inside {S_RD, S_WR, S_RMW_WR});
    fin_err = tmo_hit || (state == S_RESP && hold);
    rd_word = (state == S_RD) ? core_data_i : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gnt_q       <= GNT_IBUS;
      last_gnt    <= GNT_IBUS;
      hold        <= 1'b0;
      tmo_cnt     <= '0;
      rdbuf       <= '0;
      core_cyc_o  <= 1'b0;
      core_stb_o  <= 1'b0;
      core_we_o   <= 1'b0;
      core_addr_o <= '0;
      core_data_o <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      unique case (state)
        S_IDLE: if (i_pend || d_pend) begin
          gnt_q       <= sel;
          last_gnt    <= sel;
          core_addr_o <= s_addr & WORD_ALIGN_MASK;
          tmo_cnt     <= '0;
          if (s_bad) begin
            // no bus cycle; RESP spends one extra cycle before the err
            state <= S_RESP;
            hold  <= 1'b1;
          end else begin
            core_cyc_o <= 1'b1;
            core_stb_o <= 1'b1;
            if (!s_rw) begin
              state <= S_RD;
            end else if (s_full) begin
              state       <= S_WR;
              core_we_o   <= 1'b1;
              core_data_o <= s_wdata;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_RD, S_WR, S_RMW_WR: if (fin_ok || tmo_hit) begin
          state      <= S_RESP;
          core_cyc_o <= 1'b0;
          core_stb_o <= 1'b0;
          core_we_o  <= 1'b0;
        end
        S_RMW_RD: if (core_ack_i) begin
          rdbuf      <= core_data_i;
          state      <= S_RMW_MERGE;
          core_stb_o <= 1'b0;
        end else if (tmo_hit) begin
          state      <= S_RESP;
          core_cyc_o <= 1'b0;
          core_stb_o <= 1'b0;
        end
        // cyc stays high here so the RMW is not split on the bus
        S_RMW_MERGE: begin
          state       <= S_RMW_WR;
          core_stb_o  <= 1'b1;
          core_we_o   <= 1'b1;
          core_data_o <= merge_lanes(rdbuf, s_wdata, s_ben);
          tmo_cnt     <= '0;
        end
        S_RESP: begin
          if (hold) hold  <= 1'b0;
          else      state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_ack_o   <= 1'b0;
      ibus_err_o   <= 1'b0;
      dbus_ack_o   <= 1'b0;
      dbus_err_o   <= 1'b0;
      ibus_rdata_o <= '0;
      dbus_rdata_o <= '0;
    end else begin
      ibus_ack_o   <= fin_ok  && (gnt_q == GNT_IBUS);
      ibus_err_o   <= fin_err && (gnt_q == GNT_IBUS);
      dbus_ack_o   <= fin_ok  && (gnt_q == GNT_DBUS);
      dbus_err_o   <= fin_err && (gnt_q == GNT_DBUS);
      ibus_rdata_o <= (fin_ok && gnt_q == GNT_IBUS) ? rd_word : 32'h0;
      dbus_rdata_o <= (fin_ok && gnt_q == GNT_DBUS) ? rd_word : 32'h0;
    end
  end

endmodule

// File: tb/tb_neorv32_wb_bridge.sv
// Bench for neorv32_wb_bridge: Wishbone memory slave, reference
// memory model, directed steps plus randomized transactions.
module tb_neorv32_wb_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ibus_stb = 0;
  logic [31:0] ibus_addr = '0;
  logic [31:0] ibus_rdata;
  logic        ibus_ack, ibus_err;
  logic        dbus_stb = 0, dbus_rw = 0, dbus_amo = 0;
  logic [31:0] dbus_addr = '0, dbus_wdata = '0;
  logic [3:0]  dbus_ben = '0;
  logic [31:0] dbus_rdata;
  logic        dbus_ack, dbus_err;
  logic        cyc, stb, we;
  logic [31:0] caddr, cdo;
  logic [31:0] cdi = '0;
  logic        cack = 1'b0;

  // second instance: partial stores rejected, slave never answers
  logic        z_stb = 0;
  logic [31:0] z_irdata, z_drdata, z_caddr, z_cdo;
  logic        z_iack, z_ierr, z_dack, z_derr, z_cyc, z_cstb, z_we;

  neorv32_wb_bridge #(.TIMEOUT_CYCLES(8), .RMW_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_stb_i(ibus_stb), .ibus_addr_i(ibus_addr),
    .ibus_rdata_o(ibus_rdata), .ibus_ack_o(ibus_ack),
    .ibus_err_o(ibus_err),
    .dbus_stb_i(dbus_stb), .dbus_rw_i(dbus_rw),
    .dbus_addr_i(dbus_addr), .dbus_wdata_i(dbus_wdata),
    .dbus_ben_i(dbus_ben), .dbus_amo_i(dbus_amo),
    .dbus_rdata_o(dbus_rdata), .dbus_ack_o(dbus_ack),
    .dbus_err_o(dbus_err),
    .core_cyc_o(cyc), .core_stb_o(stb), .core_we_o(we),
    .core_addr_o(caddr), .core_data_o(cdo),
    .core_data_i(cdi), .core_ack_i(cack)
  );

  neorv32_wb_bridge #(.TIMEOUT_CYCLES(255), .RMW_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ibus_stb_i(1'b0), .ibus_addr_i(32'h0),
    .ibus_rdata_o(z_irdata), .ibus_ack_o(z_iack),
    .ibus_err_o(z_ierr),
    .dbus_stb_i(z_stb), .dbus_rw_i(1'b1),
    .dbus_addr_i(32'h80), .dbus_wdata_i(32'h0000_5500),
    .dbus_ben_i(4'b0010), .dbus_amo_i(1'b0),
    .dbus_rdata_o(z_drdata), .dbus_ack_o(z_dack),
    .dbus_err_o(z_derr),
    .core_cyc_o(z_cyc), .core_stb_o(z_cstb), .core_we_o(z_we),
    .core_addr_o(z_caddr), .core_data_o(z_cdo),
    .core_data_i(32'h0), .core_ack_i(1'b0)
  );

  // memory slave with one-cycle registered ack
  logic [31:0] mem [16];
  logic        no_ack = 0;
  logic        pl_we = 0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int n_brd = 0, n_bwr = 0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    if (stb && !cack && !no_ack) begin
      cack <= 1'b1;
      cdi  <= mem[caddr[5:2]];
      if (we) begin
        mem[caddr[5:2]] <= cdo;
        n_bwr <= n_bwr + 1;
      end else begin
        n_brd <= n_brd + 1;
      end
    end else begin
      cack <= 1'b0;
    end
  end

  int          cyc_rises = 0, cyc_hi = 0, i_pulses = 0, d_pulses = 0;
  logic        cyc_d = 0, z_cyc_seen = 0;
  logic [31:0] last_addr = '0;

  always @(posedge clk) begin
    cyc_d <= cyc;
    if (cyc && !cyc_d) cyc_rises <= cyc_rises + 1;
    if (cyc) cyc_hi <= cyc_hi + 1;
    if (ibus_ack || ibus_err) i_pulses <= i_pulses + 1;
    if (dbus_ack || dbus_err) d_pulses <= d_pulses + 1;
    if (z_cyc) z_cyc_seen <= 1'b1;
    if (stb) last_addr <= caddr;
  end

  int n_vec = 0, n_err = 0;
  logic [31:0] ref_mem [16];

  localparam logic [3:0] IA = 4'b1000;
  localparam logic [3:0] DA = 4'b0010;
  localparam logic [3:0] DE = 4'b0001;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] old,
    input logic [31:0] wd, input logic [3:0] ben);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (ben[b]) m = m | (32'hFF << (8 * b));
    return (old & ~m) | (wd & m);
  endfunction

  task automatic issue_i(input logic [31:0] a);
    ibus_addr = a;
    ibus_stb  = 1'b1;
  endtask

  task automatic issue_d(input logic rw, input logic [31:0] a,
    input logic [31:0] wd, input logic [3:0] ben, input logic amo);
    dbus_rw    = rw;
    dbus_addr  = a;
    dbus_wdata = wd;
    dbus_ben   = ben;
    dbus_amo   = amo;
    dbus_stb   = 1'b1;
  endtask

  task automatic wait_resp(input int maxc, output int lat,
    output logic [3:0] code, output logic [31:0] rd);
    lat = 0;
    code = '0;
    rd = '0;
    for (int k = 1; k <= maxc; k++) begin
      tick;
      ibus_stb = 1'b0;
      dbus_stb = 1'b0;
      if (ibus_ack || ibus_err || dbus_ack || dbus_err) begin
        lat  = k;
        code = {ibus_ack, ibus_err, dbus_ack, dbus_err};
        rd   = (ibus_ack || ibus_err) ? ibus_rdata : dbus_rdata;
        break;
      end
    end
  endtask

  initial begin
    int lat, c0, c1, c2, kind, idx, elat;
    logic [3:0]  code, eben, ecode;
    logic [31:0] rd, a, wd, erd;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      if (i == 0) ref_mem[i] = 32'h1122_3344;
      if (i == 1) ref_mem[i] = 32'hDEAD_BEEF;
      pl_idx = 4'(i);
      pl_val = ref_mem[i];
      pl_we  = 1'b1;
      tick;
    end
    pl_we = 1'b0;

    chk("reset_outputs", 64'(|{ibus_rdata, ibus_ack, ibus_err,
        dbus_rdata, dbus_ack, dbus_err, cyc, stb, we, caddr, cdo}), 0);
    chk("reset_outputs_rmw0", 64'(|{z_iack, z_ierr, z_dack, z_derr,
        z_cyc, z_cstb, z_we, z_caddr, z_drdata}), 0);
    rst_n = 1'b1;
    tick;

    // basic fetch
    c0 = d_pulses;
    c1 = i_pulses;
    issue_i(32'h104);
    tick;
    ibus_stb = 1'b0;
    tick;
    chk("fetch_bus", {cyc, stb, we, caddr}, {3'b110, 32'h104});
    wait_resp(10, lat, code, rd);
    chk("fetch_lat", 64'(lat + 2), 4);
    chk("fetch_code", code, IA);
    chk("fetch_rdata", rd, 32'hDEAD_BEEF);
    tick;
    chk("fetch_no_dbus", 64'(d_pulses - c0), 0);
    chk("fetch_one_ack", 64'(i_pulses - c1), 1);

    // tie: dbus first, then ibus
    issue_i(32'h108);
    issue_d(1'b0, 32'h10C, 32'h0, 4'hF, 1'b0);
    wait_resp(10, lat, code, rd);
    chk("tie1_first", {lat[7:0], code, rd}, {8'd4, DA, ref_mem[3]});
    wait_resp(10, lat, code, rd);
    chk("tie1_second", {lat[7:0], code, rd}, {8'd4, IA, ref_mem[2]});
    issue_d(1'b0, 32'h114, 32'h0, 4'hF, 1'b0);
    wait_resp(10, lat, code, rd);
    chk("lone_dbus", {lat[7:0], code, rd}, {8'd4, DA, ref_mem[5]});
    issue_i(32'h118);
    issue_d(1'b0, 32'h11C, 32'h0, 4'hF, 1'b0);
    wait_resp(10, lat, code, rd);
    chk("tie2_first", {lat[7:0], code, rd}, {8'd4, IA, ref_mem[6]});
    wait_resp(10, lat, code, rd);
    chk("tie2_second", {lat[7:0], code, rd}, {8'd4, DA, ref_mem[7]});

    // partial store via RMW
    tick;
    c0 = cyc_rises;
    c1 = n_brd;
    c2 = n_bwr;
    issue_d(1'b1, 32'h40, 32'h0000_AA00, 4'b0010, 1'b0);
    wait_resp(20, lat, code, rd);
    ref_mem[0] = ref_merge(ref_mem[0], 32'h0000_AA00, 4'b0010);
    chk("rmw_lat", 64'(lat), 7);
    chk("rmw_code", code, DA);
    tick;
    chk("rmw_mem", mem[0], 32'h1122_AA44);
    chk("rmw_cyc_once", 64'(cyc_rises - c0), 1);
    chk("rmw_phases", {32'(n_brd - c1), 32'(n_bwr - c2)}, {32'd1, 32'd1});

    // timeout with silent slave
    no_ack = 1'b1;
    c0 = cyc_hi;
    issue_d(1'b0, 32'h44, 32'h0, 4'hF, 1'b0);
    wait_resp(30, lat, code, rd);
    chk("tmo_lat", 64'(lat), 10);
    chk("tmo_code", code, DE);
    tick;
    chk("tmo_cyc_cycles", 64'(cyc_hi - c0), 8);
    no_ack = 1'b0;

    // atomic request rejected without a bus cycle
    c0 = cyc_rises;
    issue_d(1'b1, 32'h48, 32'h1234_5678, 4'hF, 1'b1);
    wait_resp(10, lat, code, rd);
    chk("amo_resp", {lat[7:0], code, rd}, {8'd3, DE, 32'h0});
    tick;
    chk("amo_no_cyc", 64'(cyc_rises - c0), 0);

    // partial store with RMW disabled
    lat = 0;
    z_stb = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      z_stb = 1'b0;
      if (z_derr || z_dack) begin
        lat = k;
        break;
      end
    end
    chk("normw_lat", 64'(lat), 3);
    chk("normw_kind", {z_dack, z_derr, z_iack, z_ierr}, 4'b0100);
    tick;
    chk("normw_no_cyc", 64'(z_cyc_seen), 0);

    // randomized traffic against the reference memory
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      idx  = int'($urandom_range(0, 15));
      a    = $urandom;
      a    = (a & 32'hFFFF_FFC3) | (32'(idx) << 2);
      wd   = $urandom;
      eben = 4'($urandom_range(1, 14));
      elat = 4;
      ecode = DA;
      erd  = 32'h0;
      unique case (kind)
        0: begin
          issue_i(a);
          ecode = IA;
          erd = ref_mem[idx];
        end
        1: begin
          issue_d(1'b0, a, wd, eben, 1'b0);
          erd = ref_mem[idx];
        end
        2: begin
          issue_d(1'b1, a, wd, 4'hF, 1'b0);
          ref_mem[idx] = wd;
        end
        default: begin
          issue_d(1'b1, a, wd, eben, 1'b0);
          ref_mem[idx] = ref_merge(ref_mem[idx], wd, eben);
          elat = 7;
        end
      endcase
      wait_resp(20, lat, code, rd);
      chk($sformatf("rnd%0d_resp", t), {lat[7:0], code, rd},
          {8'(elat), ecode, erd});
      chk($sformatf("rnd%0d_addr", t), last_addr, a & 32'hFFFF_FFFC);
    end
    tick;
    tick;
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    // reset during the write phase of an RMW
    c0 = d_pulses;
    issue_d(1'b1, 32'h4C, 32'h0000_00EE, 4'b0001, 1'b0);
    tick;
    dbus_stb = 1'b0;
    repeat (4) tick;
    chk("rmw_wr_phase", {cyc, stb, we}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(|{ibus_rdata, ibus_ack, ibus_err,
        dbus_rdata, dbus_ack, dbus_err, cyc, stb, we, caddr, cdo}), 0);
    tick;
    rst_n = 1'b1;
    tick;
    issue_i(32'h104);
    wait_resp(10, lat, code, rd);
    chk("post_reset_fetch", {lat[7:0], code, rd},
        {8'd4, IA, ref_mem[1]});
    repeat (3) tick;
    chk("post_reset_mem", mem[3], ref_mem[3]);
    chk("lost_request", 64'(d_pulses - c0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
